// File: rtl/arcade_ctrl_pkg.sv
// Shared types and defaults for the Space Race cabinet controls.
// Counts assume clk_sys = 57.272 MHz.
package arcade_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COIN  = 2'd1,
    START = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  localparam int P1 = 0;
  localparam int P2 = 1;

  localparam int unsigned CLK_SYS_HZ = 57272000;

  // ~10.5 ms coin switch, comfortably above the 10 ms the core needs
  localparam int unsigned COIN_PULSE_CNT_DEF  = 600000;
  // ~1.05 ms start switch
  localparam int unsigned START_PULSE_CNT_DEF = 60000;
  // ~5.2 ms quiet time between pulses
  localparam int unsigned GAP_CNT_DEF         = 300000;

  // Counter width able to hold the largest of the three intervals
  function automatic int cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // One-hot player choice; rr selects the winner when both request
  function automatic logic [1:0] pick_player(
    input logic [1:0] req,
    input logic       rr
  );
    if (&req) return rr ? 2'b10 : 2'b01;
    return req;
  endfunction

endpackage

// File: rtl/coin_start_sequencer_edge_sync.sv
// Two-flop synchronizer with rising-edge detect per bit.
// rise_o is high for one cycle after a synchronized 0->1.
module edge_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] prev_q;

  // Metastability chain plus previous-value register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/coin_start_sequencer.sv
// Coin/start pulse sequencer for both players with round-robin
// arbitration and credit-lamp gating of coin requests.
module coin_start_sequencer
  import arcade_ctrl_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CNT  = COIN_PULSE_CNT_DEF,
  parameter int unsigned START_PULSE_CNT = START_PULSE_CNT_DEF,
  parameter int unsigned GAP_CNT         = GAP_CNT_DEF
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] coin_req,
  input  logic [1:0] start_req,
  input  logic       credit_light_n,
  output logic       coin_sw,
  output logic       start_game,
  output logic       busy,
  output logic [1:0] grant,
  output logic       coin_rejected,
  output logic [7:0] coin_count
);

  localparam int CNT_W =
    cnt_width(COIN_PULSE_CNT, START_PULSE_CNT, GAP_CNT);

  localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_PULSE_CNT - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_PULSE_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CNT - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       count_q, count_d;
  logic [1:0]       coin_pend_q, coin_pend_d;
  logic [1:0]       start_pend_q, start_pend_d;
  logic             coin_sw_q, start_q, rej_q, rej_d;

  logic [3:0] rise;
  logic [1:0] coin_clr, start_clr;
  logic [1:0] coin_pick, start_pick;
  logic       decide;
  logic       coin_any, start_any;
  logic       coin_go, coin_rej, start_go;

  edge_sync #(
    .W (4)
  ) u_sync (
    .clk_i  (clk_sys),
    .rst_i  (reset),
    .d_i    ({start_req, coin_req}),
    .rise_o (rise)
  );

  assign coin_any  = |coin_pend_q;
  assign start_any = |start_pend_q;
  assign coin_go   = coin_any & credit_light_n;
  assign coin_rej  = coin_any & ~credit_light_n;
  assign start_go  = ~coin_go & start_any;

  assign coin_pick  = pick_player(coin_pend_q, rr_q);
  assign start_pick = pick_player(start_pend_q, rr_q);

  // Next state, counter reload, arbitration and pending clears.
  // The last GAP cycle dispatches directly so pulses sit GAP_CNT apart.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    rr_d      = rr_q;
    grant_d   = grant_q;
    count_d   = count_q;
    coin_clr  = 2'b00;
    start_clr = 2'b00;
    rej_d     = 1'b0;
    decide    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        decide = 1'b1;
      end
      COIN: begin
        if (cnt_q == COIN_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          grant_d = 2'b00;
        end
      end
      START: begin
        if (cnt_q == START_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          grant_d = 2'b00;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          decide  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (decide) begin
      if (coin_rej) begin
        coin_clr = 2'b11;
        rej_d    = 1'b1;
      end
      unique case (1'b1)
        coin_go: begin
          state_d  = COIN;
          cnt_d    = '0;
          grant_d  = coin_pick;
          coin_clr = coin_pick;
          count_d  = count_q + 8'd1;
          if (&coin_pend_q) rr_d = ~rr_q;
        end
        start_go: begin
          state_d   = START;
          cnt_d     = '0;
          grant_d   = start_pick;
          start_clr = start_pick;
          if (&start_pend_q) rr_d = ~rr_q;
        end
        default: begin
        end
      endcase
    end
  end

  // A fresh edge wins over a same-cycle clear so it is not lost
  always_comb begin
    coin_pend_d  = (coin_pend_q & ~coin_clr) | rise[1:0];
    start_pend_d = (start_pend_q & ~start_clr) | rise[3:2];
  end

  // State, counter, arbiter and registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_q         <= 1'b0;
      grant_q      <= 2'b00;
      count_q      <= 8'd0;
      coin_pend_q  <= 2'b00;
      start_pend_q <= 2'b00;
      coin_sw_q    <= 1'b0;
      start_q      <= 1'b0;
      rej_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      count_q      <= count_d;
      coin_pend_q  <= coin_pend_d;
      start_pend_q <= start_pend_d;
      coin_sw_q    <= (state_d == COIN);
      start_q      <= (state_d == START);
      rej_q        <= rej_d;
    end
  end

  assign coin_sw       = coin_sw_q;
  assign start_game    = start_q;
  assign busy          = (state_q != IDLE);
  assign grant         = grant_q;
  assign coin_rejected = rej_q;
  assign coin_count    = count_q;

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Directed bench for coin_start_sequencer with short intervals.
// Coin 10, start 4, gap 5 cycles.
module tb_coin_start_sequencer;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] coin_req = 2'b00;
  logic [1:0] start_req = 2'b00;
  logic       credit_light_n = 1'b1;
  logic       coin_sw;
  logic       start_game;
  logic       busy;
  logic [1:0] grant;
  logic       coin_rejected;
  logic [7:0] coin_count;

  int checks = 0;
  int errors = 0;

  coin_start_sequencer #(
    .COIN_PULSE_CNT  (10),
    .START_PULSE_CNT (4),
    .GAP_CNT         (5)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .coin_req       (coin_req),
    .start_req      (start_req),
    .credit_light_n (credit_light_n),
    .coin_sw        (coin_sw),
    .start_game     (start_game),
    .busy           (busy),
    .grant          (grant),
    .coin_rejected  (coin_rejected),
    .coin_count     (coin_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // One-cycle coin pulse, then wait until the first pulse cycle
  task automatic coin_and_wait(input logic [1:0] v);
    coin_req = v;
    tick(1);
    coin_req = 2'b00;
    tick(3);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++;
    if (coin_sw !== 1'b0) begin
      errors++;
      $display("FAIL reset.coin_sw got %b want 0", coin_sw);
    end
    checks++;
    if (start_game !== 1'b0) begin
      errors++;
      $display("FAIL reset.start_game got %b want 0", start_game);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset.busy got %b want 0", busy);
    end
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL reset.grant got %b want 00", grant);
    end
    checks++;
    if (coin_rejected !== 1'b0) begin
      errors++;
      $display("FAIL reset.coin_rejected got %b want 0", coin_rejected);
    end
    checks++;
    if (coin_count !== 8'd0) begin
      errors++;
      $display("FAIL reset.coin_count got %0d want 0", coin_count);
    end
  endtask

  task automatic test_coin_p1;
    logic       esw, ebusy;
    logic [1:0] eg;
    credit_light_n = 1'b1;
    coin_req = 2'b01;
    tick(1);
    coin_req = 2'b00;
    tick(2);
    checks++;
    if (coin_sw !== 1'b0) begin
      errors++;
      $display("FAIL coin_p1.latency got %b want 0", coin_sw);
    end
    tick(1);
    checks++;
    if (coin_count !== 8'd1) begin
      errors++;
      $display("FAIL coin_p1.count got %0d want 1", coin_count);
    end
    for (int j = 0; j < 16; j++) begin
      esw   = (j < 10);
      ebusy = (j < 15);
      eg    = (j < 10) ? 2'b01 : 2'b00;
      checks++;
      if (coin_sw !== esw) begin
        errors++;
        $display("FAIL coin_p1.coin_sw j=%0d got %b want %b", j, coin_sw, esw);
      end
      checks++;
      if (busy !== ebusy) begin
        errors++;
        $display("FAIL coin_p1.busy j=%0d got %b want %b", j, busy, ebusy);
      end
      checks++;
      if (grant !== eg) begin
        errors++;
        $display("FAIL coin_p1.grant j=%0d got %b want %b", j, grant, eg);
      end
      tick(1);
    end
  endtask

  task automatic test_coin_rejected;
    credit_light_n = 1'b0;
    coin_and_wait(2'b01);
    checks++;
    if (coin_rejected !== 1'b1) begin
      errors++;
      $display("FAIL reject.pulse got %b want 1", coin_rejected);
    end
    checks++;
    if (coin_sw !== 1'b0) begin
      errors++;
      $display("FAIL reject.coin_sw got %b want 0", coin_sw);
    end
    tick(1);
    checks++;
    if (coin_rejected !== 1'b0) begin
      errors++;
      $display("FAIL reject.single got %b want 0", coin_rejected);
    end
    credit_light_n = 1'b1;
    tick(5);
    checks++;
    if (coin_sw !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject.after got sw=%b busy=%b want 0 0", coin_sw, busy);
    end
    checks++;
    if (coin_count !== 8'd1) begin
      errors++;
      $display("FAIL reject.count got %0d want 1", coin_count);
    end
  endtask

  task automatic rr_pair(input logic [1:0] g1, input logic [1:0] g2,
                         input logic [7:0] ecnt);
    logic       esw;
    logic [1:0] eg;
    coin_and_wait(2'b11);
    for (int j = 0; j < 30; j++) begin
      esw = (j < 10) || (j >= 15 && j < 25);
      eg  = (j < 10) ? g1 : ((j >= 15 && j < 25) ? g2 : 2'b00);
      checks++;
      if (coin_sw !== esw) begin
        errors++;
        $display("FAIL rr.coin_sw j=%0d got %b want %b", j, coin_sw, esw);
      end
      checks++;
      if (grant !== eg) begin
        errors++;
        $display("FAIL rr.grant j=%0d got %b want %b", j, grant, eg);
      end
      tick(1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr.idle got %b want 0", busy);
    end
    checks++;
    if (coin_count !== ecnt) begin
      errors++;
      $display("FAIL rr.count got %0d want %0d", coin_count, ecnt);
    end
  endtask

  task automatic test_round_robin;
    credit_light_n = 1'b1;
    rr_pair(2'b01, 2'b10, 8'd3);
    rr_pair(2'b10, 2'b01, 8'd5);
  endtask

  task automatic test_start_during_coin;
    logic       esw, est;
    logic [1:0] eg;
    coin_and_wait(2'b01);
    for (int j = 0; j < 25; j++) begin
      if (j == 2) start_req = 2'b10;
      if (j == 3) start_req = 2'b00;
      esw = (j < 10);
      est = (j >= 15 && j < 19);
      eg  = esw ? 2'b01 : (est ? 2'b10 : 2'b00);
      checks++;
      if (coin_sw !== esw) begin
        errors++;
        $display("FAIL start.coin_sw j=%0d got %b want %b", j, coin_sw, esw);
      end
      checks++;
      if (start_game !== est) begin
        errors++;
        $display("FAIL start.start_game j=%0d got %b want %b", j, start_game, est);
      end
      checks++;
      if (grant !== eg) begin
        errors++;
        $display("FAIL start.grant j=%0d got %b want %b", j, grant, eg);
      end
      tick(1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start.idle got %b want 0", busy);
    end
    checks++;
    if (coin_count !== 8'd6) begin
      errors++;
      $display("FAIL start.count got %0d want 6", coin_count);
    end
  endtask

  task automatic test_absorb;
    int   npulse;
    logic prev;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    npulse = 0;
    prev = 1'b0;
    coin_and_wait(2'b01);
    for (int j = 0; j < 40; j++) begin
      if (j == 1 || j == 3 || j == 5) coin_req = 2'b01;
      if (j == 2 || j == 4 || j == 6) coin_req = 2'b00;
      if (coin_sw && !prev) npulse++;
      prev = coin_sw;
      tick(1);
    end
    checks++;
    if (npulse !== 2) begin
      errors++;
      $display("FAIL absorb.pulses got %0d want 2", npulse);
    end
    checks++;
    if (coin_count !== 8'd2) begin
      errors++;
      $display("FAIL absorb.count got %0d want 2", coin_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL absorb.idle got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_pulse;
    int nhi;
    coin_and_wait(2'b01);
    tick(4);
    checks++;
    if (coin_sw !== 1'b1) begin
      errors++;
      $display("FAIL rstmid.before got %b want 1", coin_sw);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (coin_sw !== 1'b0) begin
      errors++;
      $display("FAIL rstmid.async_drop got %b want 0", coin_sw);
    end
    checks++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL rstmid.state got busy=%b grant=%b want 0 00", busy, grant);
    end
    tick(2);
    reset = 1'b0;
    nhi = 0;
    for (int j = 0; j < 30; j++) begin
      tick(1);
      if (coin_sw || start_game) nhi++;
    end
    checks++;
    if (nhi !== 0) begin
      errors++;
      $display("FAIL rstmid.no_resume got %0d want 0", nhi);
    end
    checks++;
    if (coin_count !== 8'd0) begin
      errors++;
      $display("FAIL rstmid.count got %0d want 0", coin_count);
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_coin_p1();
    test_coin_rejected();
    test_round_robin();
    test_start_during_coin();
    test_absorb();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
